sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_sequencer_if.sv | 32 +++
 rtl/sound_sequencer.sv | 155 +++++++++++++++
 tb/tb_sound_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/sound_sequencer_if.sv
// Event inputs and tone-control outputs for the sound sequencer.
// The master side raises the push/speed events and the mute level; the slave
// side (the sequencer) drives sound select, audible gate and busy.
interface sound_sequencer_if;
  logic       push_right;
  logic       push_left;
  logic       speed_round;
  logic       mute;
  logic [1:0] soundType;
  logic       sound_on;
  logic       busy;

  modport master (
    output push_right,
    output push_left,
    output speed_round,
    output mute,
    input  soundType,
    input  sound_on,
    input  busy
  );

  modport slave (
    input  push_right,
    input  push_left,
    input  speed_round,
    input  mute,
    output soundType,
    output sound_on,
    output busy
  );
endinterface

// File: rtl/sound_sequencer.sv
// Game sound sequencer: turns push / speed-round pulses into timed tones
// followed by a silent gap, with a single-entry pending slot so that one
// event arriving mid-tone is played right after the gap.
//
// state | meaning
// IDLE  | silent, waiting for an event
// PLAY  | tone audible, counter runs TONE_CYCLES
// GAP   | silent gap, counter runs GAP_CYCLES; launches pending at expiry
module sound_sequencer #(
  parameter int unsigned TONE_CYCLES = 10000000,
  parameter int unsigned GAP_CYCLES  = 2000000
) (
  input  logic             clk,
  input  logic             rst,
  sound_sequencer_if.slave bus
);

  localparam logic [1:0]  CODE_RIGHT = 2'd0;
  localparam logic [1:0]  CODE_LEFT  = 2'd1;
  localparam logic [1:0]  CODE_SPEED = 2'd2;
  // Counter holds "cycles remaining minus one", so a state lasts LOAD+1 cycles.
  localparam logic [23:0] TONE_LOAD  = 24'(TONE_CYCLES - 1);
  localparam logic [23:0] GAP_LOAD   = 24'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pend_v_q, pend_v_d;
  logic [1:0]  pend_c_q, pend_c_d;
  logic [1:0]  type_q, type_d;
  logic        sound_on_q, sound_on_d;
  logic        busy_q, busy_d;

  logic        ev_valid;
  logic [1:0]  ev_code;
  logic        ev_wins;

  // Priority rank of a sound code: speed > right > left.
  function automatic logic [1:0] rank(input logic [1:0] code);
    case (code)
      CODE_SPEED: rank = 2'd2;
      CODE_RIGHT: rank = 2'd1;
      default:    rank = 2'd0;
    endcase
  endfunction

  // Reduce simultaneous events to the highest-priority one and decide
  // whether it beats the pending entry (ties replace it).
  always_comb begin
    ev_valid = bus.speed_round | bus.push_right | bus.push_left;
    if (bus.speed_round)     ev_code = CODE_SPEED;
    else if (bus.push_right) ev_code = CODE_RIGHT;
    else                     ev_code = CODE_LEFT;
    ev_wins = ev_valid && (!pend_v_q || (rank(ev_code) >= rank(pend_c_q)));
  end

  // Next-state, counter, pending slot and registered-output values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pend_v_d = pend_v_q;
    pend_c_d = pend_c_q;
    type_d   = type_q;

    if (bus.mute) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pend_v_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ev_valid) begin
            state_d = PLAY;
            cnt_d   = TONE_LOAD;
            type_d  = ev_code;
          end
        end
        PLAY: begin
          if (ev_wins) begin
            pend_v_d = 1'b1;
            pend_c_d = ev_code;
          end
          if (cnt_q == '0) begin
            state_d = GAP;
            cnt_d   = GAP_LOAD;
          end else begin
            cnt_d = cnt_q - 24'd1;
          end
        end
        GAP: begin
          if (cnt_q == '0) begin
            // Launch candidate is the winner of pending vs this cycle's event.
            if (ev_wins) begin
              state_d = PLAY;
              cnt_d   = TONE_LOAD;
              type_d  = ev_code;
            end else if (pend_v_q) begin
              state_d = PLAY;
              cnt_d   = TONE_LOAD;
              type_d  = pend_c_q;
            end else begin
              state_d = IDLE;
            end
            pend_v_d = 1'b0;
          end else begin
            if (ev_wins) begin
              pend_v_d = 1'b1;
              pend_c_d = ev_code;
            end
            cnt_d = cnt_q - 24'd1;
          end
        end
        default: begin
          state_d  = IDLE;
          cnt_d    = '0;
          pend_v_d = 1'b0;
        end
      endcase
    end

    sound_on_d = (state_d == PLAY);
    busy_d     = (state_d != IDLE) || pend_v_d;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      pend_v_q   <= 1'b0;
      pend_c_q   <= CODE_RIGHT;
      type_q     <= CODE_RIGHT;
      sound_on_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_v_q   <= pend_v_d;
      pend_c_q   <= pend_c_d;
      type_q     <= type_d;
      sound_on_q <= sound_on_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.soundType = type_q;
  assign bus.sound_on  = sound_on_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Directed bench for sound_sequencer with TONE_CYCLES=8, GAP_CYCLES=4.
// "Cycle k" below means the outputs observed 1 ns after rising edge k, where
// edge 0 is the edge just before an initial event is driven.
module tb_sound_sequencer;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  sound_sequencer_if bus();

  sound_sequencer #(
    .TONE_CYCLES(8),
    .GAP_CYCLES (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    bus.push_right  = 1'b0;
    bus.push_left   = 1'b0;
    bus.speed_round = 1'b0;
  endtask

  task automatic check_outs(input string tag, input int k,
                            input logic on, input logic busy, input logic [1:0] st);
    check_val($sformatf("%s_on k=%0d", tag, k), {31'd0, bus.sound_on}, {31'd0, on});
    check_val($sformatf("%s_busy k=%0d", tag, k), {31'd0, bus.busy}, {31'd0, busy});
    check_val($sformatf("%s_type k=%0d", tag, k), {30'd0, bus.soundType}, {30'd0, st});
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.mute = 1'b0;
    clear_events();
    rst = 1'b1;
    repeat (3) tick();
    check_outs("reset", 0, 1'b0, 1'b0, 2'd0);
    rst = 1'b0;
    tick();

    // Single left push: tone on cycles 1-8, gap 9-12, idle from 13.
    bus.push_left = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      clear_events();
      check_outs("single", k, (k <= 8), (k <= 12), 2'd1);
    end

    // All three together: speed wins, single tone, nothing pending.
    bus.push_left   = 1'b1;
    bus.push_right  = 1'b1;
    bus.speed_round = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      clear_events();
      check_outs("triple", k, (k <= 8), (k <= 12), 2'd2);
    end

    // Left tone, right mid-tone becomes pending, later left dropped.
    bus.push_left = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      clear_events();
      if (k == 3) bus.push_right = 1'b1;
      if (k == 5) bus.push_left  = 1'b1;
      check_outs("pend", k, (k <= 8) || (k >= 13 && k <= 20), (k <= 24),
                 (k <= 12) ? 2'd1 : 2'd0);
    end

    // Right tone, left pending, speed on final gap cycle overrides it.
    bus.push_right = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      clear_events();
      if (k == 4)  bus.push_left   = 1'b1;
      if (k == 12) bus.speed_round = 1'b1;
      check_outs("lastgap", k, (k <= 8) || (k >= 13 && k <= 20), (k <= 24),
                 (k <= 12) ? 2'd0 : 2'd2);
    end

    // Repeated right pushes during a tone collapse into one follow-up tone.
    bus.push_left = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      clear_events();
      if (k == 2 || k == 4 || k == 10) bus.push_right = 1'b1;
      check_outs("collapse", k, (k <= 8) || (k >= 13 && k <= 20), (k <= 24),
                 (k <= 12) ? 2'd1 : 2'd0);
    end

    // Mute mid-tone with a pending entry: silent idle, nothing after release.
    bus.push_left = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      clear_events();
      if (k == 2) bus.push_right = 1'b1;
      if (k == 4) bus.mute = 1'b1;
      if (k == 5) bus.push_right = 1'b1;
      if (k == 6) bus.mute = 1'b0;
      check_outs("mute", k, (k <= 4), (k <= 4), 2'd1);
    end

    // Asynchronous reset mid-gap, then a right push one edge after release.
    bus.speed_round = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      clear_events();
      check_outs("prerst", k, (k <= 8), 1'b1, 2'd2);
    end
    #3 rst = 1'b1;
    #1 check_outs("asyncrst", 10, 1'b0, 1'b0, 2'd0);
    #1 rst = 1'b0;
    tick();
    check_outs("postrst", 0, 1'b0, 1'b0, 2'd0);
    bus.push_right = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      clear_events();
      check_outs("afterrst", k, (k <= 8), (k <= 12), 2'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
